// File: rtl/muldiv_pkg.sv
// Shared constants and helpers for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // MUL's low half is sign-agnostic; treating it as signed is harmless.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/write-back handshake bundle between the pipeline and the muldiv unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;

  modport master (
    output flush, in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result select applied in the FIX state.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]        op,
  input  logic              neg_a,
  input  logic              neg_b,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remv;

  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quot = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    // Remainder follows the dividend's sign.
    remv = neg_a ? -rem : rem;
    case (op)
      OP_MUL:                      result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result = quot;
      default:                     result = remv;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one operation in flight, valid/ready on both sides.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        out_rd_q, out_rd_d;

  logic              accept;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   fix_result;

  assign bus.in_ready   = (state_q == ST_IDLE) & ~bus.flush & ~reset;
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_result = result_q;
  assign bus.out_rd     = out_rd_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign sign_a   = is_signed_a(bus.in_op) & bus.in_rs1[XLEN-1];
  assign sign_b   = is_signed_b(bus.in_op) & bus.in_rs2[XLEN-1];
  assign mag_a    = sign_a ? -bus.in_rs1 : bus.in_rs1;
  assign mag_b    = sign_b ? -bus.in_rs2 : bus.in_rs2;
  assign div_zero = is_div(bus.in_op) && (bus.in_rs2 == '0);
  assign div_ovf  = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) &&
                    (bus.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_rs2 == '1);

  // Multiply: acc holds {partial high, remaining multiplier bits}.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  // Divide: acc[XLEN-1:0] shifts the dividend out and the quotient in.
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  muldiv_sign_fix u_sign_fix (
    .op     (op_q),
    .neg_a  (neg_a_q),
    .neg_b  (neg_b_q),
    .acc    (acc_q),
    .rem    (rem_q),
    .result (fix_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    special_d = special_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    result_d  = result_q;
    out_rd_d  = out_rd_q;

    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d      = bus.in_op;
            rd_d      = bus.in_rd;
            cnt_d     = '0;
            special_d = div_zero | div_ovf;
            if (div_zero | div_ovf) begin
              // Preload quotient/remainder with the architectural answer, no signs.
              neg_a_d = 1'b0;
              neg_b_d = 1'b0;
              a_d     = '0;
              b_d     = '0;
              acc_d   = {{XLEN{1'b0}}, (div_zero ? {XLEN{1'b1}} : bus.in_rs1)};
              rem_d   = div_zero ? bus.in_rs1 : '0;
              state_d = ST_FIX;
            end else begin
              neg_a_d = sign_a;
              neg_b_d = sign_b;
              a_d     = mag_a;
              b_d     = mag_b;
              acc_d   = {{XLEN{1'b0}}, (is_div(bus.in_op) ? mag_a : mag_b)};
              rem_d   = '0;
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (is_div(op_q)) begin
            rem_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FIX: begin
          // Special cases dwell one extra cycle here to keep a fixed 2-cycle latency.
          if (special_q && (cnt_q == '0)) begin
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d    = '0;
            result_d = fix_result;
            out_rd_d = rd_q;
            state_d  = ST_DONE;
          end
        end
        default: begin
          if (bus.out_ready) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      out_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      special_q <= special_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      out_rd_q  <= out_rd_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [4:0] rd, input string tag);
    for (int k = 0; k < 20 && !bus.in_ready; k++) step();
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Returns the number of edges after accept until out_valid is seen.
  task automatic wait_valid(output int n, output logic got);
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      step();
      n++;
      if (bus.out_valid) got = 1'b1;
    end
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [4:0] rd, input logic [63:0] exp, input int lat,
                       input string tag);
    int   n;
    logic got;
    issue(op, rs1, rs2, rd, tag);
    wait_valid(n, got);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, bus.out_result, exp);
    check({tag, "_rd"}, 64'(bus.out_rd), 64'(rd));
    retire(tag);
  endtask

  initial begin
    int   n;
    logic got;
    logic seen;
    logic [63:0] held;

    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b0;

    step();
    step();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", bus.out_result, 64'd0);
    check("rst_rd", 64'(bus.out_rd), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    step();

    do_op(OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul");
    do_op(OP_MULHU,  ONES, ONES, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu");
    do_op(OP_MULH,   ONES, ONES, 5'd7, 64'd0, 65, "mulh");
    do_op(OP_MULHSU, ONES, ONES, 5'd8, ONES, 65, "mulhsu");

    do_op(OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9,  64'hFFFF_FFFF_FFFF_FFFD, 65, "div");
    do_op(OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, ONES, 65, "rem");
    do_op(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'h7FFF_FFFF_FFFF_FFFC, 65, "divu");
    do_op(OP_REMU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'd1, 65, "remu");

    do_op(OP_DIVU, 64'd5, 64'd0, 5'd13, ONES,  2, "divu_z");
    do_op(OP_DIV,  64'd5, 64'd0, 5'd14, ONES,  2, "div_z");
    do_op(OP_REMU, 64'd5, 64'd0, 5'd15, 64'd5, 2, "remu_z");
    do_op(OP_REM,  64'd5, 64'd0, 5'd16, 64'd5, 2, "rem_z");

    do_op(OP_DIV, MINV, ONES, 5'd17, MINV,  2, "div_ovf");
    do_op(OP_REM, MINV, ONES, 5'd18, 64'd0, 2, "rem_ovf");

    // Backpressure: result must hold while write-back stalls.
    issue(OP_MULHU, ONES, ONES, 5'd19, "bp");
    wait_valid(n, got);
    check("bp_got", 64'(got), 64'd1);
    held = bus.out_result;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("bp_ready", 64'(bus.in_ready), 64'd0);
    end
    check("bp_held", bus.out_result, held);
    retire("bp");

    // Flush at CALC iteration 30.
    issue(OP_DIVU, 64'd1000, 64'd3, 5'd20, "fl");
    for (int i = 0; i < 30; i++) step();
    check("fl_busy", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    check("fl_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    check("fl_novalid", 64'(seen), 64'd0);

    // Reset mid-CALC, then a fresh operation.
    issue(OP_MUL, 64'd3, 64'd4, 5'd21, "rs");
    for (int i = 0; i < 20; i++) step();
    reset = 1'b1;
    #1;
    check("rs_valid", 64'(bus.out_valid), 64'd0);
    check("rs_result", bus.out_result, 64'd0);
    check("rs_rd", 64'(bus.out_rd), 64'd0);
    check("rs_ready", 64'(bus.in_ready), 64'd0);
    step();
    reset = 1'b0;
    step();
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    check("rs_noresult", 64'(seen), 64'd0);
    do_op(OP_MUL, 64'd6, 64'd7, 5'd22, 64'd42, 65, "rs_mul");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV64M multiply/divide execute unit. It consumes the two register-file read operands plus the destination register index. After a multi-cycle computation it returns the 64-bit result and rd to the write-back stage (WriteData/RD).
Valid/ready handshakes on input and output let the pipeline stall around it. One operation is in flight at a time.

Parameters:
XLEN, 64, operand/result width
CNT_W, 7, iteration counter width (must hold XLEN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of any in-flight operation
in_valid  input  1  operation request
in_ready  output  1  unit can accept (IDLE and not flush)
in_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in_rs1  input  XLEN  operand A (ReadData1)
in_rs2  input  XLEN  operand B (ReadData2)
in_rd  input  5  destination register tag
out_valid  output  1  result available
out_ready  input  1  write-back accepts result
out_result  output  XLEN  result (WriteData)
out_rd  output  5  destination tag (RD)

Behaviour:
- Reset: asynchronous, active-high; reset is reset, clock is clk. On reset, state=IDLE, counter=0, and all datapath registers are cleared. out_valid=0, out_result=0, out_rd=0. in_ready=1 once reset deasserts.
- Reset asserted mid-operation aborts the operation; no result is ever produced for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready = !flush. An accept (in_valid & in_ready at edge T) latches op and rd.
  - It also latches operand magnitudes: signed ops take |x| and record the sign; unsigned ops take x as-is.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
- Special cases are decided at accept, and the unit goes IDLE→FIX (skips CALC):
  - Divide by zero (rs2==0): DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (DIV/REM with rs1=0x8000_0000_0000_0000, rs2=all ones): DIV result = rs1; REM result = 0.
- Normal case: IDLE→CALC with counter=0.
- CALC runs exactly XLEN iterations, one per cycle, then moves to FIX.
  - Multiply: shift-add over a 2·XLEN accumulator.
  - Divide: restoring radix-2, shifting the dividend into a XLEN+1-bit partial remainder; a subtraction is kept when it is non-negative.
- FIX (1 cycle): apply sign correction and select the output; results are registered into out_result/out_rd, then DONE.
  - Multiply: negate the 128-bit product when the operand signs differ. MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
  - Quotient: negated when signs differ (DIV).
  - Remainder: takes the sign of the dividend (REM).
- Latency from accept edge T:
  - Normal: out_valid rises after edge T+XLEN+1 (T+65).
  - Special: out_valid rises after edge T+2.
- DONE: out_valid=1, and out_result/out_rd are held stable until out_ready. On out_valid & out_ready the unit returns to IDLE; out_valid=0 next cycle.
- No accept while not IDLE: in_ready=0 in CALC/FIX/DONE. Back-to-back operations therefore have at least one idle cycle between them.
- flush (any state): next state IDLE and out_valid=0. flush takes priority over both accept and the output handshake in the same cycle.
- All arithmetic is modulo 2^XLEN for results. Internal widths: product 2·XLEN, partial remainder XLEN+1.

Decomposition:
- Shared package muldiv_pkg holds:
  - localparams for the eight funct3 op codes;
  - the state encoding (IDLE/CALC/FIX/DONE);
  - helpers is_div(op) and is_signed_a/b(op).
- XLEN is taken from the existing core-wide width constant.
- No sub-module: a single FSM plus a shared shift datapath is natural.
- Optional sub-module muldiv_sign_fix, holding the combinational FIX-stage negation/select, only if it helps unit-level testing.

Test Plan:
- MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD (−3) → out_result=0xFFFF_FFFF_FFFF_FFEB, out_valid exactly 65 cycles after accept; out_rd equals in_rd.
- rs1=rs2=0xFFFF_FFFF_FFFF_FFFF: MULHU → 0xFFFF_FFFF_FFFF_FFFE; MULH → 0; MULHSU → 0xFFFF_FFFF_FFFF_FFFF.
- rs1=−7, rs2=2: DIV → 0xFFFF_FFFF_FFFF_FFFD (−3); REM → 0xFFFF_FFFF_FFFF_FFFF (−1); DIVU → 0x7FFF_FFFF_FFFF_FFFC; REMU → 1.
- rs1=5, rs2=0: DIVU/DIV → all ones; REMU/REM → 5; out_valid 2 cycles after accept.
- Overflow case DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000, REM → 0, latency 2.
- Backpressure and abort:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid/out_result stable, in_ready=0.
  - Assert flush at CALC iteration 30 → out_valid never rises, in_ready=1 next cycle.
  - Assert reset mid-CALC → all outputs 0 immediately, then a new op completes correctly.
